// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for round-robin arbitration blocks.
package rr_arb_pkg;

   localparam int MAX_REQ = 16;

   // Index width for n requesters; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             found_o
);

   int unsigned idx;

   // Scan farthest-first so the request closest to ptr overwrites and wins.
   always_comb begin
      gnt_idx_o = '0;
      found_o   = 1'b0;
      idx       = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = 32'(ptr_i) + 32'(k);
         if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
         if (req_i[IDX_W'(idx)]) begin
            gnt_idx_o = IDX_W'(idx);
            found_o   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_capture_arbiter.sv
// Round-robin arbiter feeding one shared capture register with a valid/ready output.
module rr_capture_arbiter
   import rr_arb_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int DATA_W = 8,
   localparam int IDX_W  = idx_w(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [IDX_W-1:0]          out_src,
   input  logic                      out_ready
);

   logic                           out_valid_q, out_valid_d;
   logic [DATA_W-1:0]              out_data_q,  out_data_d;
   logic [IDX_W-1:0]               out_src_q,   out_src_d;
   logic [IDX_W-1:0]               ptr_q,       ptr_d;
   logic [IDX_W-1:0]               gnt_idx;
   logic                           found;
   logic                           load_en;
   logic [N_REQ-1:0][DATA_W-1:0]   req_data_a;
   logic [DATA_W-1:0]              sel_data;

   assign req_data_a = req_data;
   assign sel_data   = req_data_a[gnt_idx];

   // Register may take new data when empty or being drained this cycle.
   assign load_en = !out_valid_q || out_ready;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .gnt_idx_o (gnt_idx),
      .found_o   (found)
   );

   // Grant strobe: one-hot on the winner when a capture happens, silenced in reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && load_en && found) req_ready[gnt_idx] = 1'b1;
   end

   // Next state: capture winner (and advance ptr past it), else drain, else hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      if (load_en && found) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_src_d   = gnt_idx;
         ptr_d       = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end else if (out_ready && out_valid_q) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous clear; reset drops any held data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

`ifdef FORMAL
   logic past_vld_q;

   // Arms $past checks only after a clean non-reset edge has been seen.
   always_ff @(posedge clk) past_vld_q <= rst_n;

   // Grant vector sanity and pointer range.
   always_comb begin
      assert ($onehot0(req_ready));
      assert (32'(ptr_q) < 32'(N_REQ));
   end

   // Stall holds the output; a transfer lands the selected data next cycle.
   always_ff @(posedge clk) begin
      if (past_vld_q && rst_n && $past(rst_n)) begin
         if ($past(out_valid_q && !out_ready))
            assert (out_valid_q && out_data_q == $past(out_data_q) &&
                    out_src_q == $past(out_src_q));
         if ($past(|req_ready))
            assert (out_data_q == $past(sel_data));
      end
   end
`endif

endmodule

// File: tb/tb_rr_capture_arbiter.sv
// Directed bench for rr_capture_arbiter (N_REQ=4, DATA_W=8).
module tb_rr_capture_arbiter;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [3:0]      rv;
   logic [3:0][7:0] rd;
   logic [3:0]      req_ready;
   logic            out_valid;
   logic [7:0]      out_data;
   logic [1:0]      out_src;
   logic            out_ready;

   int n_vec = 0;
   int n_err = 0;

   logic            asm_en = 1'b0;
   logic            asm_arm = 1'b0;
   logic [3:0]      pv_valid, pv_ready;
   logic [3:0][7:0] pv_data;

   always #5 clk = ~clk;

   rr_capture_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (rv),
      .req_data  (rd),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requester obligation: a pending, ungranted request stays up with stable data.
   always @(negedge clk) begin
      if (asm_en && asm_arm) begin
         for (int i = 0; i < 4; i++) begin
            if (pv_valid[i] && !pv_ready[i]) begin
               chk("hold_valid", 32'(rv[i]), 32'd1);
               chk("hold_data", 32'(rd[i]), 32'(pv_data[i]));
            end
         end
      end
      pv_valid = rv;
      pv_ready = req_ready;
      pv_data  = rd;
      asm_arm  = asm_en;
   end

   initial begin
      logic [1:0] skip_seq [3];
      skip_seq = '{2'd2, 2'd0, 2'd2};

      rst_n     = 1'b0;
      rv        = 4'hF;
      rd        = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      out_ready = 1'b1;

      // Reset held with every requester active.
      repeat (3) begin
         tick();
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_valid", 32'(out_valid), 32'd0);
         chk("rst_data",  32'(out_data),  32'd0);
         chk("rst_src",   32'(out_src),   32'd0);
      end

      // Rotation 0,1,2,3,0 at one transfer per cycle.
      rst_n  = 1'b1;
      asm_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 chk("rot_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
         tick();
         chk("rot_valid", 32'(out_valid), 32'd1);
         chk("rot_src",   32'(out_src),   32'(k % 4));
         chk("rot_data",  32'(out_data),  32'(8'hA0 + k % 4));
      end
      asm_en = 1'b0;

      // Skip idle requesters from ptr=1: 2, 0, 2.
      rv = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         #1 chk("skip_ready", 32'(req_ready), 32'(4'b0001 << skip_seq[k]));
         tick();
         chk("skip_src",  32'(out_src),  32'(skip_seq[k]));
         chk("skip_data", 32'(out_data), 32'(8'hA0 + skip_seq[k]));
      end

      // Backpressure: capture 0x55 from req 1, stall 4 cycles, then release.
      rd[1] = 8'h55;
      rv    = 4'b0010;
      #1 chk("bp_cap_ready", 32'(req_ready), 32'b0010);
      tick();
      chk("bp_cap_data", 32'(out_data), 32'h55);
      chk("bp_cap_src",  32'(out_src),  32'd1);
      out_ready = 1'b0;
      rv        = 4'hF;
      asm_en    = 1'b1;
      repeat (4) begin
         #1 chk("bp_ready", 32'(req_ready), 32'd0);
         tick();
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data",  32'(out_data),  32'h55);
         chk("bp_src",   32'(out_src),   32'd1);
      end
      out_ready = 1'b1;
      #1 chk("bp_rel_ready", 32'(req_ready), 32'b0100);
      tick();
      chk("bp_rel_src",  32'(out_src),  32'd2);
      chk("bp_rel_data", 32'(out_data), 32'hA2);
      asm_en = 1'b0;

      // Reset mid-operation while holding 0x33 with ptr away from 0.
      rd[2] = 8'h33;
      rv    = 4'b0100;
      #1 chk("mr_cap_ready", 32'(req_ready), 32'b0100);
      tick();
      chk("mr_cap_valid", 32'(out_valid), 32'd1);
      chk("mr_cap_data",  32'(out_data),  32'h33);
      rv        = 4'b0000;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1 chk("mr_ready", 32'(req_ready), 32'd0);
      tick();
      chk("mr_valid", 32'(out_valid), 32'd0);
      chk("mr_data",  32'(out_data),  32'd0);
      chk("mr_src",   32'(out_src),   32'd0);
      rst_n     = 1'b1;
      rv        = 4'hF;
      out_ready = 1'b1;
      #1 chk("mr_ptr_ready", 32'(req_ready), 32'b0001);
      tick();
      chk("mr_post_src",  32'(out_src),  32'd0);
      chk("mr_post_data", 32'(out_data), 32'hA0);

      // Drain-empty: lone 0x7E from req 3, then nothing; ptr wraps to 0.
      rd[3] = 8'h7E;
      rv    = 4'b1000;
      #1 chk("de_ready", 32'(req_ready), 32'b1000);
      tick();
      chk("de_valid", 32'(out_valid), 32'd1);
      chk("de_data",  32'(out_data),  32'h7E);
      chk("de_src",   32'(out_src),   32'd3);
      rv = 4'b0000;
      #1 chk("de_idle_ready", 32'(req_ready), 32'd0);
      tick();
      chk("de_drain_valid", 32'(out_valid), 32'd0);
      chk("de_hold_data",   32'(out_data),  32'h7E);
      chk("de_hold_src",    32'(out_src),   32'd3);
      tick();
      chk("de_empty_valid", 32'(out_valid), 32'd0);
      rv = 4'hF;
      #1 chk("de_wrap_ready", 32'(req_ready), 32'b0001);
      tick();
      chk("de_wrap_src", 32'(out_src), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
